// File: rtl/bcd_down60.sv
// Mod-60 packed-BCD down-counter with validated parallel load, borrow-out on
// the 00 -> 59 wrap, and an optional stop-at-zero mode that raises done.
module bcd_down60 #(
  parameter bit         STOP_AT_ZERO = 1'b0,
  parameter logic [7:0] RESET_VAL    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       bo,
  output logic       done,
  output logic       load_err
);

  logic [7:0] count_reg, count_next;
  logic       bo_reg, bo_next;
  logic       load_err_reg, load_err_next;
  logic [1:0] load_digit_ok;
  logic [1:0] count_digit_ok;
  logic       load_valid;
  logic       count_valid;
  logic [3:0] units;
  logic [3:0] tens;

  // Digit 0 is units (0-9), digit 1 is tens (0-5).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      localparam logic [3:0] DIGIT_MAX = (gi == 0) ? 4'd9 : 4'd5;
      assign load_digit_ok[gi]  = (load_val[4*gi +: 4] <= DIGIT_MAX);
      assign count_digit_ok[gi] = (count_reg[4*gi +: 4] <= DIGIT_MAX);
    end
  endgenerate

  assign load_valid  = &load_digit_ok;
  assign count_valid = &count_digit_ok;
  assign units       = count_reg[3:0];
  assign tens        = count_reg[7:4];

  always_comb begin
    count_next    = count_reg;
    bo_next       = 1'b0;
    load_err_next = 1'b0;
    if (load) begin
      if (load_valid) begin
        count_next = load_val;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (en) begin
      // A non-BCD count can only come from a fault; recover to the top value.
      if (!count_valid) begin
        count_next = 8'h59;
      end else if (units != 4'd0) begin
        count_next = {tens, units - 4'd1};
      end else if (tens != 4'd0) begin
        count_next = {tens - 4'd1, 4'd9};
      end else if (!STOP_AT_ZERO) begin
        count_next = 8'h59;
        bo_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= RESET_VAL;
      bo_reg       <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      bo_reg       <= bo_next;
      load_err_reg <= load_err_next;
    end
  end

  assign count    = count_reg;
  assign bo       = bo_reg;
  assign load_err = load_err_reg;
  assign done     = STOP_AT_ZERO && (count_reg == 8'h00);

endmodule

// File: tb/tb_bcd_down60.sv
// Randomized and directed check of bcd_down60 in wrap and stop-at-zero modes
// against an integer (0-59) reference model.
module tb_bcd_down60;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count_w, count_s;
  logic       bo_w, bo_s, done_w, done_s, load_err_w, load_err_s;

  int n_checks;
  int n_fail;

  // Reference state: plain integer seconds value plus expected pulses.
  int  mv_w, mv_s;
  bit  mbo_w, mbo_s, mle;

  bcd_down60 #(.STOP_AT_ZERO(1'b0), .RESET_VAL(8'h00)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(count_w), .bo(bo_w), .done(done_w), .load_err(load_err_w)
  );

  bcd_down60 #(.STOP_AT_ZERO(1'b1), .RESET_VAL(8'h00)) dut_stop (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .count(count_s), .bo(bo_s), .done(done_s), .load_err(load_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic int step_model(input int v, input bit stop, output bit b);
    b = 1'b0;
    if (v > 0) return v - 1;
    if (stop) return 0;
    b = 1'b1;
    return 59;
  endfunction

  task automatic cycle(input bit r, input bit l, input logic [7:0] lv, input bit e);
    bit valid;
    bit dummy;
    @(negedge clk);
    rst = r; load = l; load_val = lv; en = e;
    @(posedge clk);
    valid = (lv[3:0] <= 4'd9) && (lv[7:4] <= 4'd5);
    mbo_w = 1'b0; mbo_s = 1'b0; mle = 1'b0;
    if (r) begin
      mv_w = 0; mv_s = 0;
    end else if (l) begin
      if (valid) begin
        mv_w = int'(lv[7:4]) * 10 + int'(lv[3:0]);
        mv_s = mv_w;
      end else begin
        mle = 1'b1;
      end
    end else if (e) begin
      mv_w = step_model(mv_w, 1'b0, mbo_w);
      mv_s = step_model(mv_s, 1'b1, dummy);
    end
    #1;
    check("count_wrap", int'(count_w), int'(to_bcd(mv_w)));
    check("bo_wrap", int'(bo_w), int'(mbo_w));
    check("done_wrap", int'(done_w), 0);
    check("load_err_wrap", int'(load_err_w), int'(mle));
    check("count_stop", int'(count_s), int'(to_bcd(mv_s)));
    check("bo_stop", int'(bo_s), int'(mbo_s));
    check("done_stop", int'(done_s), int'(mv_s == 0));
    check("load_err_stop", int'(load_err_s), int'(mle));
    $display("t=%0t rst=%0b load=%0b lv=%02h en=%0b | wrap cnt=%02h bo=%0b le=%0b | stop cnt=%02h done=%0b",
             $time, r, l, lv, e, count_w, bo_w, load_err_w, count_s, done_s);
  endtask

  initial begin
    int bo_pulses;
    logic [7:0] lv;
    n_checks = 0; n_fail = 0;
    mv_w = 0; mv_s = 0; mbo_w = 0; mbo_s = 0; mle = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 8'h00;

    // Reset for two cycles, then idle.
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 0);

    // Wrap: 02 -> 01, 00, 59, 58.
    cycle(0, 1, 8'h02, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);

    // Full period from 59: exactly one borrow, digits always in range.
    cycle(0, 1, 8'h59, 0);
    bo_pulses = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(0, 0, 8'h00, 1);
      if (bo_w) bo_pulses++;
      check("units_range", int'(count_w[3:0] <= 4'd9), 1);
      check("tens_range", int'(count_w[7:4] <= 4'd5), 1);
    end
    check("full_period_end", int'(count_w), 32'h59);
    check("full_period_bo", bo_pulses, 1);

    // Load validation.
    cycle(0, 1, 8'h5A, 1);
    cycle(0, 0, 8'h00, 0);
    cycle(0, 1, 8'h63, 1);
    cycle(0, 1, 8'h45, 0);

    // Load beats en; rst beats load.
    cycle(0, 1, 8'h12, 0);
    cycle(0, 1, 8'h30, 1);
    cycle(1, 1, 8'h27, 1);

    // Stop mode: 01 then four enabled cycles.
    cycle(0, 1, 8'h01, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1) == 0)
        lv = {4'($urandom_range(5)), 4'($urandom_range(9))};
      else
        lv = 8'($urandom);
      cycle(($urandom_range(99) < 2), ($urandom_range(99) < 15), lv,
            ($urandom_range(99) < 75));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_down60.md
Name: bcd_down60

Overview:
- Mod-60 BCD down-counter with parallel load and borrow-out.
- Counterpart to the mod-60 up-counter used for the seconds/minutes chain.
- Produces two packed BCD digits in the same format as the up-counter: [7:4] tens 0-5, [3:0] units 0-9.
- Cascades through the borrow output, so stages chain into countdown timers (e.g. MM:SS).

Parameters:
- STOP_AT_ZERO, 0: 0 = wrap 00 -> 59 with borrow pulse; 1 = hold at 00 and assert done.
- RESET_VAL, 8'h00: value loaded into count on reset; must be valid BCD in 00-59.

Ports:
- clk  input  1  rising-edge system clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable; one decrement per clk when high
- load  input  1  parallel load strobe
- load_val  input  8  packed BCD value to load
- count  output  8  packed BCD count
- bo  output  1  borrow-out; one-cycle pulse on 00 -> 59 wrap
- done  output  1  count == 00 while STOP_AT_ZERO=1; always 0 otherwise
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset, evaluated on clk edge while rst=1:
  - count = RESET_VAL, bo = 0, load_err = 0.
  - done = (RESET_VAL == 8'h00 && STOP_AT_ZERO).
  - rst overrides load and en.
- Priority each cycle: rst > load > en.
- Load (load=1):
  - Valid when load_val[3:0] <= 9 and load_val[7:4] <= 5.
  - Valid: count <= load_val next cycle; bo = 0; en ignored that cycle.
  - Invalid: count unchanged, load_err = 1 for one cycle, en ignored that cycle.
- Decrement (en=1, load=0):
  - Units != 0: units -= 1.
  - Units == 0 and tens != 0: units = 9, tens -= 1.
  - Count == 00, STOP_AT_ZERO=0: count = 59, bo = 1 for exactly that cycle, registered with count.
  - Count == 00, STOP_AT_ZERO=1: count holds 00, bo stays 0.
- en=0: count holds, bo = 0.
- Output timing:
  - bo is registered and high in the same cycle count shows 59 after a wrap.
  - All outputs change only on clk edges; no combinational path from inputs to outputs.
- done is combinational from registered count: (count == 8'h00) && STOP_AT_ZERO.
- Illegal internal states cannot be reached: loads are validated and reset values are constrained.
  - Defensive rule: if count is ever non-BCD, the next en cycle forces count = 59.
- Cascading: upper stage en = lower stage bo; the upper stage decrements in the cycle after the lower wraps.
- Reset mid-count: count returns to RESET_VAL on that edge; any pending bo is cleared.

Test Plan:
- Reset: rst=1 for 2 cycles, then en=0 -> count=00, bo=0, load_err=0; count holds 00 for 5 cycles.
- Wrap (STOP_AT_ZERO=0): load 8'h02, then en=1 -> count sequence 01, 00, 59, 58; bo=1 only in the cycle count=59.
- Full period: from 59, en=1 for 60 cycles -> count returns to 59; exactly one bo pulse; units always 0-9 and tens always 0-5 in every cycle.
- Load validation:
  - load_val=8'h5A -> load_err=1 for one cycle, count unchanged.
  - load_val=8'h63 -> rejected the same way.
  - load_val=8'h45 -> count=45, load_err=0.
- Simultaneous events:
  - load=1, en=1, load_val=8'h30 at count=12 -> count=30 (no decrement).
  - rst=1 with load=1 -> count=RESET_VAL.
- Stop mode (STOP_AT_ZERO=1): load 8'h01, then en=1 for 4 cycles -> count 00 and stays 00, done=1 from the cycle count reaches 00, bo never asserts.
